tm1637_digit_sequencer: RTL and testbench
=========================================

// Module: tm1637_digit_sequencer
// PURPOSE
//  Downstream of the bcd converter. Latches four BCD digits (thousands..ones),
//  encodes them to TM1637 7-segment codes with optional leading-zero blanking and
//  colon, and emits one full TM1637 update frame as a byte stream over a
//  valid/ready handshake to the TM1637 bit serializer (which owns start/stop).
// PARAMETERS
//  BLANK_LEADING  1      1: blank leading zeros (ones digit never blanked); 0: show all
//  INVALID_SEG    8'h40  segment code for BCD values 10..15 (dash)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  asynchronous active-low reset
//  thousands   in   4  BCD digit 0 (leftmost)
//  hundreds    in   4  BCD digit 1
//  tens        in   4  BCD digit 2
//  ones        in   4  BCD digit 3 (rightmost)
//  colon       in   1  light colon (bit7 of digit 1 segment byte)
//  brightness  in   3  TM1637 pulse width 0..7
//  display_on  in   1  display enable bit in control command
//  update      in   1  request a frame (level sampled each clock)
//  busy        out  1  frame in progress
//  byte_data   out  8  byte to serializer
//  byte_valid  out  1  byte_data valid
//  byte_last   out  1  serializer issues STOP after this byte
//  byte_ready  in   1  serializer accepts byte (handshake = valid & ready)
//  frame_done  out  1  one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset (async, immediate): busy/byte_valid/byte_last/frame_done=0, byte_data=8'h00,
//   FSM=IDLE, pending=0, latched inputs=0. Reset mid-frame aborts; no resume.
//  Frame (7 bytes, in order; L = byte_last=1):
//   CMD_DATA 8'h40 L | CMD_ADDR 8'hC0 | DIG0 | DIG1 | DIG2 | DIG3 L |
//   CMD_CTRL {4'b1000|display_on<<3 ... } = 8'h80 | display_on<<3 | brightness, L
//  FSM: IDLE -> CMD_DATA -> CMD_ADDR -> DIG0 -> DIG1 -> DIG2 -> DIG3 -> CMD_CTRL -> IDLE.
//   Leaving IDLE: on update=1. All other transitions only on handshake cycle.
//  Latch: digits, colon, brightness, display_on captured on the clock that leaves
//   IDLE; input changes during a frame do not affect it.
//  Latency: byte_valid=1 with 8'h40 the cycle after update sampled in IDLE; busy=1
//   same cycle. Next byte presented the cycle after each handshake (one byte per
//   cycle when byte_ready held 1: 7 cycles per frame).
//  Handshake: byte_data/byte_last stable while byte_valid & !byte_ready; no byte
//   skipped or repeated; byte_valid never drops before accepted.
//  frame_done: 1 for one cycle, the clock after CMD_CTRL handshake; busy falls same clock.
//  Pending: update=1 while busy sets pending (multiple collapse to one). At frame end,
//   if pending: clear it, re-latch current inputs, start new frame directly
//   (CMD_DATA presented the cycle frame_done pulses, busy stays 1).
//  Segment map (bit0=a..bit6=g): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F;
//   10..15 -> INVALID_SEG.
//  Blanking (BLANK_LEADING=1): DIG0 blank if thousands==0; DIG1 if thousands,hundreds==0;
//   DIG2 if thousands,hundreds,tens==0; blank = 8'h00. Invalid digits count as nonzero.
//  Colon: DIG1 bit7 = latched colon, ORed after blanking (blank digit + colon = 8'h80).
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0, busy=0; hold update=0 after release -> no bytes.
//  2 digits 1,2,3,4 colon=0 bright=7 on=1, ready=1: update pulse -> 40L,C0,06,5B,4F,66L,
//    8FL on 7 consecutive cycles; frame_done pulse next cycle; busy=0.
//  3 Blanking: 0,0,0,7 -> digits 00,00,00,07; 0,0,0,0 -> 00,00,00,3F; 0,0,4,2 colon=1
//    -> 00,80,66,5B; BLANK_LEADING=0 with 0,0,0,7 -> 3F,3F,3F,07; 0xA -> 40; on=0 bright=3 -> 83.
//  4 Backpressure: ready=0 for 3 cycles while DIG2 valid -> byte_data holds 4F, then
//    sequence continues with no skip/duplicate; random ready -> byte order matches test 2.
//  5 Pending: two update pulses during frame, inputs changed to 9,9,9,9 -> exactly one
//    follow-on frame, digits 6F x4, busy high throughout, two frame_done pulses total.
//  6 Reset mid-frame at DIG1: byte_valid drops asynchronously; after release IDLE,
//    no output until next update, which produces a full frame from 8'h40.

Source files
------------

// File: rtl/tm1637_digit_sequencer.sv
// TM1637 digit sequencer: latches four BCD digits plus display settings and
// streams one complete TM1637 update frame (data cmd, address cmd, four
// segment bytes, control cmd) to the bit serializer over valid/ready.
module tm1637_digit_sequencer #(
  parameter bit         BLANK_LEADING = 1'b1,
  parameter logic [7:0] INVALID_SEG   = 8'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       colon,
  input  logic [2:0] brightness,
  input  logic       display_on,
  input  logic       update,
  output logic       busy,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_last,
  input  logic       byte_ready,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, CMD_DATA, CMD_ADDR, DIG0, DIG1, DIG2, DIG3, CMD_CTRL
  } state_t;

  localparam logic [7:0] CMD_DATA_BYTE = 8'h40;
  localparam logic [7:0] CMD_ADDR_BYTE = 8'hC0;

  state_t     state;
  logic       pending;
  logic [3:0] th_q, hu_q, te_q, on_q_dig;
  logic       colon_q, disp_q;
  logic [2:0] bright_q;

  logic       hs;
  logic       start;
  logic       blank0, blank1, blank2;
  logic [7:0] dig0_b, dig1_b, dig2_b, dig3_b, ctrl_b;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = INVALID_SEG;
    endcase
  endfunction

  assign hs = byte_valid & byte_ready;

  // A frame starts from IDLE on update, or back-to-back when the control byte
  // is accepted with a request outstanding (including one arriving that cycle).
  assign start = ((state == IDLE) && update) ||
                 ((state == CMD_CTRL) && hs && (pending || update));

  // Segment bytes from the latched frame values, with leading-zero blanking.
  always_comb begin
    blank0 = BLANK_LEADING && (th_q == 4'd0);
    blank1 = blank0 && (hu_q == 4'd0);
    blank2 = blank1 && (te_q == 4'd0);
    dig0_b = blank0 ? '0 : seg7(th_q);
    dig1_b = (blank1 ? '0 : seg7(hu_q)) | {colon_q, 7'b0};
    dig2_b = blank2 ? '0 : seg7(te_q);
    dig3_b = seg7(on_q_dig);
    ctrl_b = {4'b1000, disp_q, bright_q};
  end

  // Frame inputs are captured only when a frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q     <= '0;
      hu_q     <= '0;
      te_q     <= '0;
      on_q_dig <= '0;
      colon_q  <= 1'b0;
      disp_q   <= 1'b0;
      bright_q <= '0;
    end else if (start) begin
      th_q     <= thousands;
      hu_q     <= hundreds;
      te_q     <= tens;
      on_q_dig <= ones;
      colon_q  <= colon;
      disp_q   <= display_on;
      bright_q <= brightness;
    end
  end

  // Frame sequencer: presents each byte registered, advances only on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      busy       <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (update) begin
          state      <= CMD_DATA;
          busy       <= 1'b1;
          byte_valid <= 1'b1;
          byte_data  <= CMD_DATA_BYTE;
          byte_last  <= 1'b1;
        end
      end else begin
        if (update) pending <= 1'b1;
        if (hs) begin
          case (state)
            CMD_DATA: begin
              state     <= CMD_ADDR;
              byte_data <= CMD_ADDR_BYTE;
              byte_last <= 1'b0;
            end
            CMD_ADDR: begin
              state     <= DIG0;
              byte_data <= dig0_b;
              byte_last <= 1'b0;
            end
            DIG0: begin
              state     <= DIG1;
              byte_data <= dig1_b;
              byte_last <= 1'b0;
            end
            DIG1: begin
              state     <= DIG2;
              byte_data <= dig2_b;
              byte_last <= 1'b0;
            end
            DIG2: begin
              state     <= DIG3;
              byte_data <= dig3_b;
              byte_last <= 1'b1;
            end
            DIG3: begin
              state     <= CMD_CTRL;
              byte_data <= ctrl_b;
              byte_last <= 1'b1;
            end
            CMD_CTRL: begin
              frame_done <= 1'b1;
              // The clear here overrides the set above, so a request arriving
              // on this cycle is consumed by the restarted frame.
              pending    <= 1'b0;
              if (pending || update) begin
                state     <= CMD_DATA;
                byte_data <= CMD_DATA_BYTE;
                byte_last <= 1'b1;
              end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                byte_valid <= 1'b0;
                byte_data  <= '0;
                byte_last  <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1637_digit_sequencer.sv
// Scoreboard bench for tm1637_digit_sequencer: a frame-level reference model
// pushes expected byte streams when a frame starts; a monitor pops them as the
// DUTs hand bytes over. Two instances cover both blanking settings.
module tb_tm1637_digit_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] thousands = '0, hundreds = '0, tens = '0, ones = '0;
  logic       colon = 1'b0;
  logic [2:0] brightness = '0;
  logic       display_on = 1'b0;
  logic       update = 1'b0;
  logic       byte_ready = 1'b1;

  logic       busy1, valid1, last1, done1;
  logic [7:0] data1;
  logic       busy0, valid0, last0, done0;
  logic [7:0] data0;

  int nchk = 0;
  int nerr = 0;
  int fd_cnt = 0;
  bit rmode = 1'b0;

  // reference model state
  bit          m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_pend = 1'b0;
  int unsigned m_idx = 0;
  logic [8:0]  q1[$];
  logic [8:0]  q0[$];
  logic [7:0]  segtbl[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  always #5 clk = ~clk;

  tm1637_digit_sequencer #(.BLANK_LEADING(1'b1), .INVALID_SEG(8'h40)) dut1 (
    .clk(clk), .rst_n(rst_n), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .colon(colon), .brightness(brightness),
    .display_on(display_on), .update(update), .busy(busy1),
    .byte_data(data1), .byte_valid(valid1), .byte_last(last1),
    .byte_ready(byte_ready), .frame_done(done1));

  tm1637_digit_sequencer #(.BLANK_LEADING(1'b0), .INVALID_SEG(8'h40)) dut0 (
    .clk(clk), .rst_n(rst_n), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .colon(colon), .brightness(brightness),
    .display_on(display_on), .update(update), .busy(busy0),
    .byte_data(data0), .byte_valid(valid0), .byte_last(last0),
    .byte_ready(byte_ready), .frame_done(done0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Expected frame {last,data} for the current inputs.
  task automatic push_frame(input bit blank);
    logic [3:0]  d[4];
    logic [7:0]  b[4];
    int unsigned lead;
    d = '{thousands, hundreds, tens, ones};
    lead = 0;
    while (lead < 3 && d[lead] == 4'd0) lead++;
    for (int unsigned i = 0; i < 4; i++) begin
      b[i] = (d[i] < 4'd10) ? segtbl[d[i]] : 8'h40;
      if (blank && i < lead) b[i] = 8'h00;
    end
    if (colon) b[1] = b[1] | 8'h80;
    if (blank) begin
      q1.push_back({1'b1, 8'h40}); q1.push_back({1'b0, 8'hC0});
      q1.push_back({1'b0, b[0]});  q1.push_back({1'b0, b[1]});
      q1.push_back({1'b0, b[2]});  q1.push_back({1'b1, b[3]});
      q1.push_back({1'b1, 8'h80 + 8'(display_on) * 8'd8 + 8'(brightness)});
    end else begin
      q0.push_back({1'b1, 8'h40}); q0.push_back({1'b0, 8'hC0});
      q0.push_back({1'b0, b[0]});  q0.push_back({1'b0, b[1]});
      q0.push_back({1'b0, b[2]});  q0.push_back({1'b1, b[3]});
      q0.push_back({1'b1, 8'h80 + 8'(display_on) * 8'd8 + 8'(brightness)});
    end
  endtask

  task automatic start_frame();
    m_busy = 1'b1;
    m_valid = 1'b1;
    m_idx = 0;
    push_frame(1'b1);
    push_frame(1'b0);
  endtask

  // Frame-level model: 7 bytes per frame, one per accepted handshake.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_idx = 0;
        q1.delete(); q0.delete();
      end else begin
        bit hs;
        hs = m_valid && byte_ready;
        m_done = 1'b0;
        if (!m_busy) begin
          if (update) start_frame();
        end else begin
          if (update) m_pend = 1'b1;
          if (hs) begin
            if (m_idx == 6) begin
              m_done = 1'b1;
              if (m_pend) begin
                m_pend = 1'b0;
                start_frame();
              end else begin
                m_busy = 1'b0;
                m_valid = 1'b0;
              end
            end else begin
              m_idx++;
            end
          end
        end
      end
    end
  end

  task automatic mon(input bit which, input logic v, input logic [7:0] dat,
                     input logic l, input logic b, input logic fd);
    string tag;
    logic [8:0] e;
    tag = which ? "blank1" : "blank0";
    chk({tag, " byte_valid"}, 32'(v), 32'(m_valid));
    chk({tag, " busy"}, 32'(b), 32'(m_busy));
    chk({tag, " frame_done"}, 32'(fd), 32'(m_done));
    if (v) begin
      if ((which ? q1.size() : q0.size()) == 0) begin
        nchk++; nerr++;
        $display("FAIL %s unexpected byte at %0t: got %h expected none", tag, $time, dat);
      end else begin
        e = which ? q1[0] : q0[0];
        chk({tag, " byte{last,data}"}, 32'({l, dat}), 32'(e));
        if (byte_ready) begin
          if (which) void'(q1.pop_front()); else void'(q0.pop_front());
        end
      end
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (done1) fd_cnt++;
      mon(1'b1, valid1, data1, last1, busy1, done1);
      mon(1'b0, valid0, data0, last0, busy0, done0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rmode) byte_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse();
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while ((m_busy || busy1 || busy0) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      nchk++; nerr++;
      $display("FAIL wait_idle timeout at %0t: busy=%b expected 0", $time, busy1);
    end
    step();
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic col, input logic [2:0] br,
                        input logic on);
    thousands = a; hundreds = b; tens = c; ones = d;
    colon = col; brightness = br; display_on = on;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " busy1"}, 32'(busy1), 0);
    chk({nm, " valid1"}, 32'(valid1), 0);
    chk({nm, " last1"}, 32'(last1), 0);
    chk({nm, " data1"}, 32'(data1), 0);
    chk({nm, " done1"}, 32'(done1), 0);
    chk({nm, " valid0"}, 32'(valid0), 0);
    chk({nm, " data0"}, 32'(data0), 0);
  endtask

  initial begin
    int fd_before;
    // reset
    rst_n = 1'b0;
    #23;
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // basic frame
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 3'd7, 1'b1);
    pulse();
    wait_idle();

    // blanking, colon, invalid digit, control byte
    set_in(4'd0, 4'd0, 4'd0, 4'd7, 1'b0, 3'd7, 1'b1); pulse(); wait_idle();
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd7, 1'b1); pulse(); wait_idle();
    set_in(4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 3'd7, 1'b1); pulse(); wait_idle();
    set_in(4'd0, 4'hA, 4'd0, 4'd1, 1'b0, 3'd7, 1'b1); pulse(); wait_idle();
    set_in(4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 3'd3, 1'b0); pulse(); wait_idle();

    // backpressure while DIG2 is presented
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 3'd7, 1'b1);
    pulse();
    for (int i = 0; i < 20 && m_idx != 4; i++) step();
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("hold DIG2 data", 32'(data1), 32'h4F);
    byte_ready = 1'b1;
    wait_idle();

    // random backpressure on the same frame
    rmode = 1'b1;
    pulse();
    wait_idle();
    rmode = 1'b0;
    byte_ready = 1'b1;

    // pending requests collapse into one follow-on frame
    fd_before = fd_cnt;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 3'd7, 1'b1);
    pulse();
    step();
    set_in(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 3'd7, 1'b1);
    pulse();
    step();
    pulse();
    wait_idle();
    chk("pending frame_done count", 32'(fd_cnt - fd_before), 32'd2);

    // reset mid-frame while DIG1 is presented
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 3'd7, 1'b1);
    pulse();
    for (int i = 0; i < 20 && m_idx != 3; i++) step();
    byte_ready = 1'b0;
    #1;
    chk("mid-frame valid before reset", 32'(valid1), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    step();
    step();
    rst_n = 1'b1;
    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    pulse();
    wait_idle();

    // randomized inputs, requests and backpressure
    rmode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      update = ($urandom_range(0, 9) == 0);
      step();
    end
    update = 1'b0;
    wait_idle();
    rmode = 1'b0;
    byte_ready = 1'b1;
    step();

    chk("scoreboard q1 drained", q1.size(), 0);
    chk("scoreboard q0 drained", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
